multdiv_controller: RTL and testbench
=====================================

# multdiv_controller

Sequences the multi-cycle multiplier/divider for the execute stage of the five-stage pipeline. The block detects `mul`/`div` instructions, issues a one-cycle start to the multdiv unit and freezes the front of the pipeline until the result is ready. It then presents the result and any overflow or divide exception to the X/M latch. A watchdog bounds the wait; a flush from branch resolution aborts an in-flight operation.

## Interface
- `MAX_CYCLES`, 40, watchdog limit in RUN cycles before forced completion (≥2)
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low; low forces IDLE and clears all registers
- `inst_x`  in  32  instruction in execute stage
- `valid_x`  in  1  `inst_x` is a live (non-bubble) instruction
- `flush`  in  1  squash execute-stage instruction this cycle
- `md_result`  in  32  multdiv unit result
- `md_rdy`  in  1  multdiv result valid (level, sampled only in RUN)
- `md_exc`  in  1  multdiv overflow / divide-by-zero, qualified by `md_rdy`
- `start_mult`  out  1  one-cycle start to multiplier
- `start_div`  out  1  one-cycle start to divider
- `stall`  out  1  hold PC, F/D and D/X registers; insert bubble into X/M
- `result`  out  32  captured result for X/M latch
- `result_valid`  out  1  `result` valid this cycle
- `exc_valid`  out  1  write `exc_code` to rstatus ($r30) this cycle
- `exc_code`  out  3  4 = mul exception, 5 = div exception
- `timeout`  out  1  one-cycle pulse: watchdog fired

## Operation
- Decode: `md_req = valid_x & ~flush & (inst_x[31:27]==0) & (inst_x[6:2]==6 | inst_x[6:2]==7)`; ALU op 6 = mul, 7 = div.
- States: IDLE, RUN, DONE (2-bit encoding). A registered `op_is_div` flag and a `$clog2(MAX_CYCLES)`-bit counter back them.
- IDLE: if `md_req`, assert `start_mult` (op 6) or `start_div` (op 7) combinationally, latch `op_is_div`, clear the counter and go to RUN. Otherwise stay.
- RUN: the counter increments each cycle.
  - `flush`: go to IDLE, no result, no exception, discard any `md_rdy`.
  - Else `md_rdy`: latch `md_result` into `result` and `md_exc` into the exception flag, then go to DONE.
  - Else counter == `MAX_CYCLES-1`: latch `result`=0, set the exception flag, pulse `timeout`, go to DONE.
- DONE: `result_valid`=1. `exc_valid` equals the latched flag. `exc_code` = `op_is_div ? 5 : 4`. Unconditional return to IDLE.
- `stall` = `(IDLE & md_req) | RUN`, combinational. It is low in DONE so the instruction advances with its result.
- When `exc_valid`=1, `result` is still presented. The writeback path redirects the destination to $r30; this block does not alter `result`.
- `start_mult`/`start_div` are never high together and never high outside IDLE.

## Timing
- Reset values: state IDLE, `result`=0, `result_valid`=0, `exc_valid`=0, `exc_code`=0, `timeout`=0, counter 0. `start_*` and `stall` are 0 because they derive from IDLE with `valid_x` gated.
- Mid-operation reset returns to IDLE asynchronously with no outputs asserted. Any later `md_rdy` is ignored until a new start.
- Issue at cycle T (IDLE, start high, stall high). Unit asserts `md_rdy` at T+k (k≥1). DONE at T+k+1 with `result_valid` and stall low. Total stall = k+1 cycles.
- `md_rdy` asserted at T (same cycle as start) is not sampled.
- Back-to-back: a new `md_req` is seen in the IDLE cycle following DONE. There is a minimum of one non-stalled cycle between two operations.
- Watchdog: with no `md_rdy`, DONE occurs at T+`MAX_CYCLES`+1 and `timeout` pulses in that DONE cycle.
- `flush` and `md_rdy` in the same RUN cycle: flush wins.
- `result_valid`, `exc_valid` and `timeout` are single-cycle. `result` holds its value until the next capture.

## Test plan
- Mul, `md_rdy` 3 cycles after start, `md_result`=0x0000_0F00, `md_exc`=0 -> `start_mult` for 1 cycle, `stall` high 4 cycles, then `result_valid`=1 with 0x0000_0F00, `exc_valid`=0.
- Div with `md_exc`=1 at k=5 -> `start_div` pulse, DONE at T+6, `exc_valid`=1, `exc_code`=5.
- Two consecutive muls -> two `start_mult` pulses separated by DONE+IDLE, two `result_valid` pulses with the correct values, no lost instruction.
- `flush` in the second RUN cycle of a div, `md_rdy` later -> back to IDLE, no `result_valid`/`exc_valid`, stall released the next cycle.
- `MAX_CYCLES`=8, `md_rdy` never asserted -> `timeout` and `exc_valid` (`exc_code`=4 for mul) at T+9, `result`=0.
- `reset` low during RUN, then high with `md_rdy`=1 -> all outputs 0, no `result_valid`; a non-md `inst_x` produces no stall.

Source files
------------

// File: rtl/multdiv_controller.sv
// Execute-stage sequencer for the multi-cycle multiplier/divider: issues a start,
// stalls the front end until the unit answers, flushes or the watchdog fires.
module multdiv_controller #(
  parameter int MAX_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inst_x,
  input  logic        valid_x,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_rdy,
  input  logic        md_exc,
  output logic        start_mult,
  output logic        start_div,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        exc_valid,
  output logic [2:0]  exc_code,
  output logic        timeout
);

  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [4:0] OP_MUL = 5'd6;
  localparam logic [4:0] OP_DIV = 5'd7;
  localparam logic [2:0] EXC_MUL = 3'd4;
  localparam logic [2:0] EXC_DIV = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             op_is_div_q, op_is_div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             exc_valid_q, exc_valid_d;
  logic [2:0]       exc_code_q, exc_code_d;
  logic             timeout_q, timeout_d;

  logic is_mul_s, is_div_s, md_req_s;
  logic start_mult_s, start_div_s, stall_s;
  logic unused_inst_bits_s;

  assign unused_inst_bits_s = ^{inst_x[26:7], inst_x[1:0]};

  // Decode a live, unflushed mul/div in the execute stage.
  always_comb begin
    is_mul_s = (inst_x[31:27] == 5'd0) && (inst_x[6:2] == OP_MUL);
    is_div_s = (inst_x[31:27] == 5'd0) && (inst_x[6:2] == OP_DIV);
    md_req_s = valid_x && !flush && (is_mul_s || is_div_s);
  end

  // Next-state and registered-output computation; DONE outputs are set on entry.
  always_comb begin
    state_d        = state_q;
    op_is_div_d    = op_is_div_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    exc_valid_d    = 1'b0;
    exc_code_d     = 3'd0;
    timeout_d      = 1'b0;
    start_mult_s   = 1'b0;
    start_div_s    = 1'b0;
    stall_s        = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_req_s) begin
          start_mult_s = is_mul_s;
          start_div_s  = is_div_s;
          stall_s      = 1'b1;
          op_is_div_d  = is_div_s;
          cnt_d        = {CNT_W{1'b0}};
          state_d      = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        stall_s = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Flush beats a simultaneous md_rdy: the instruction is gone.
        if (flush) begin
          state_d = IDLE;
        end else if (md_rdy) begin
          result_d       = md_result;
          exc_valid_d    = md_exc;
          result_valid_d = 1'b1;
          exc_code_d     = op_is_div_q ? EXC_DIV : EXC_MUL;
          state_d        = DONE;
        end else if (cnt_q == CNT_LAST) begin
          result_d       = 32'd0;
          exc_valid_d    = 1'b1;
          result_valid_d = 1'b1;
          timeout_d      = 1'b1;
          exc_code_d     = op_is_div_q ? EXC_DIV : EXC_MUL;
          state_d        = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      op_is_div_q    <= 1'b0;
      cnt_q          <= {CNT_W{1'b0}};
      result_q       <= 32'd0;
      result_valid_q <= 1'b0;
      exc_valid_q    <= 1'b0;
      exc_code_q     <= 3'd0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_is_div_q    <= op_is_div_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      exc_valid_q    <= exc_valid_d;
      exc_code_q     <= exc_code_d;
      timeout_q      <= timeout_d;
    end
  end

  assign start_mult   = start_mult_s;
  assign start_div    = start_div_s;
  assign stall        = stall_s;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign exc_valid    = exc_valid_q;
  assign exc_code     = exc_code_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_multdiv_controller.sv
// Directed bench for multdiv_controller with MAX_CYCLES=8; control outputs are
// checked as {start_mult,start_div,stall,result_valid,exc_valid,timeout,exc_code}.
module tb_multdiv_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inst_x;
  logic        valid_x, flush;
  logic [31:0] md_result;
  logic        md_rdy, md_exc;
  logic        start_mult, start_div, stall;
  logic [31:0] result;
  logic        result_valid, exc_valid, timeout;
  logic [2:0]  exc_code;
  logic [8:0]  ctl_s;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] INST_MUL = 32'h0000_0018;
  localparam logic [31:0] INST_DIV = 32'h0000_001C;
  localparam logic [8:0]  C_IDLE   = 9'b0_0_0_0_0_0_000;
  localparam logic [8:0]  C_ISSM   = 9'b1_0_1_0_0_0_000;
  localparam logic [8:0]  C_ISSD   = 9'b0_1_1_0_0_0_000;
  localparam logic [8:0]  C_RUN    = 9'b0_0_1_0_0_0_000;

  multdiv_controller #(.MAX_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .inst_x(inst_x), .valid_x(valid_x), .flush(flush),
    .md_result(md_result), .md_rdy(md_rdy), .md_exc(md_exc),
    .start_mult(start_mult), .start_div(start_div), .stall(stall), .result(result),
    .result_valid(result_valid), .exc_valid(exc_valid), .exc_code(exc_code), .timeout(timeout)
  );

  always #5 clock = ~clock;

  assign ctl_s = {start_mult, start_div, stall, result_valid, exc_valid, timeout, exc_code};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [8:0] exp);
    chk(tag, {23'd0, ctl_s}, {23'd0, exp});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; inst_x = 32'd0; valid_x = 1'b0; flush = 1'b0;
    md_result = 32'd0; md_rdy = 1'b0; md_exc = 1'b0;
    #2;
    chk_ctl("reset_ctl", C_IDLE);
    chk("reset_result", result, 32'd0);
    tick(); tick();
    reset = 1'b1; #1;
    chk_ctl("post_reset_ctl", C_IDLE);

    // Mul, md_rdy three cycles after start.
    tick(); inst_x = INST_MUL; valid_x = 1'b1; #1;
    chk_ctl("t1_issue", C_ISSM);
    tick(); #1; chk_ctl("t1_run1", C_RUN);
    tick(); #1; chk_ctl("t1_run2", C_RUN);
    tick(); md_rdy = 1'b1; md_result = 32'h0000_0F00; #1;
    chk_ctl("t1_run3", C_RUN);
    tick(); md_rdy = 1'b0; md_result = 32'd0; #1;
    chk_ctl("t1_done", 9'b0_0_0_1_0_0_100);
    chk("t1_result", result, 32'h0000_0F00);
    tick(); valid_x = 1'b0; #1;
    chk_ctl("t1_after", C_IDLE);
    chk("t1_result_hold", result, 32'h0000_0F00);

    // Div with exception at k=5.
    tick(); inst_x = INST_DIV; valid_x = 1'b1; #1;
    chk_ctl("t2_issue", C_ISSD);
    for (int i = 1; i <= 4; i++) begin
      tick(); #1; chk_ctl("t2_run", C_RUN);
    end
    tick(); md_rdy = 1'b1; md_exc = 1'b1; md_result = 32'hDEAD_BEEF; #1;
    chk_ctl("t2_run5", C_RUN);
    tick(); md_rdy = 1'b0; md_exc = 1'b0; md_result = 32'd0; #1;
    chk_ctl("t2_done", 9'b0_0_0_1_1_0_101);
    chk("t2_result", result, 32'hDEAD_BEEF);
    tick(); valid_x = 1'b0; #1;
    chk_ctl("t2_after", C_IDLE);

    // Watchdog: mul with no md_rdy, DONE at T+9.
    tick(); inst_x = INST_MUL; valid_x = 1'b1; #1;
    chk_ctl("t5_issue", C_ISSM);
    for (int i = 1; i <= 8; i++) begin
      tick(); #1; chk_ctl("t5_run", C_RUN);
    end
    tick(); #1;
    chk_ctl("t5_done", 9'b0_0_0_1_1_1_100);
    chk("t5_result", result, 32'd0);
    tick(); valid_x = 1'b0; #1;
    chk_ctl("t5_after", C_IDLE);

    // Back-to-back muls.
    tick(); inst_x = INST_MUL; valid_x = 1'b1; #1;
    chk_ctl("t3_issue_a", C_ISSM);
    tick(); md_rdy = 1'b1; md_result = 32'h0000_0011; #1;
    chk_ctl("t3_run_a", C_RUN);
    tick(); md_rdy = 1'b0; md_result = 32'd0; #1;
    chk_ctl("t3_done_a", 9'b0_0_0_1_0_0_100);
    chk("t3_result_a", result, 32'h0000_0011);
    tick(); #1;
    chk_ctl("t3_issue_b", C_ISSM);
    chk("t3_result_hold", result, 32'h0000_0011);
    tick(); md_rdy = 1'b1; md_result = 32'h0000_0022; #1;
    chk_ctl("t3_run_b", C_RUN);
    tick(); md_rdy = 1'b0; md_result = 32'd0; #1;
    chk_ctl("t3_done_b", 9'b0_0_0_1_0_0_100);
    chk("t3_result_b", result, 32'h0000_0022);
    tick(); valid_x = 1'b0; #1;
    chk_ctl("t3_after", C_IDLE);

    // Flushed mul in IDLE issues nothing.
    inst_x = INST_MUL; valid_x = 1'b1; flush = 1'b1; #1;
    chk_ctl("idle_flush", C_IDLE);

    // Div flushed in its second RUN cycle, together with md_rdy.
    tick(); inst_x = INST_DIV; flush = 1'b0; #1;
    chk_ctl("t4_issue", C_ISSD);
    tick(); #1; chk_ctl("t4_run1", C_RUN);
    tick(); flush = 1'b1; md_rdy = 1'b1; md_result = 32'h0000_0099; #1;
    chk_ctl("t4_run2_flush", C_RUN);
    tick(); flush = 1'b0; valid_x = 1'b0; #1;
    chk_ctl("t4_released", C_IDLE);
    tick(); #1;
    chk_ctl("t4_late_rdy", C_IDLE);
    chk("t4_result_hold", result, 32'h0000_0022);
    md_rdy = 1'b0;

    // Reset in RUN, then md_rdy after release.
    tick(); inst_x = INST_MUL; valid_x = 1'b1; #1;
    chk_ctl("t6_issue", C_ISSM);
    tick(); #1; chk_ctl("t6_run", C_RUN);
    reset = 1'b0; valid_x = 1'b0; #1;
    chk_ctl("t6_in_reset", C_IDLE);
    chk("t6_reset_result", result, 32'd0);
    tick(); reset = 1'b1; md_rdy = 1'b1; md_result = 32'h0000_0077; #1;
    chk_ctl("t6_rdy_ignored_a", C_IDLE);
    tick(); #1;
    chk_ctl("t6_rdy_ignored_b", C_IDLE);
    chk("t6_result", result, 32'd0);
    md_rdy = 1'b0; inst_x = 32'h2800_0018; valid_x = 1'b1; #1;
    chk_ctl("t6_nonmd_opcode", C_IDLE);
    tick(); inst_x = 32'h0000_0020; #1;
    chk_ctl("t6_nonmd_aluop", C_IDLE);
    valid_x = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
